// File: rtl/mipi_pkg.sv
// Shared definitions for the MIPI pair scheduler: scheduler states,
// lane/pair widths and the word-packing helper.
package mipi_pkg;

  localparam int LANE_W = 8;
  localparam int PAIR_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FLUSH = 2'd3
  } state_t;

  // Lane B occupies the upper byte of the stitched word.
  function automatic logic [PAIR_W-1:0] pack_pair(input logic [LANE_W-1:0] b_byte,
                                                  input logic [LANE_W-1:0] a_byte);
    return {b_byte, a_byte};
  endfunction

endpackage

// File: rtl/mipi_lane_fifo.sv
// Per-lane byte FIFO with synchronous clear. DEPTH must be a power of two
// (>= 2) so the read/write pointers wrap naturally.
module mipi_lane_fifo
  import mipi_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [LANE_W-1:0]        din,
  output logic [LANE_W-1:0]        head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   occ
);

  localparam int AW = $clog2(DEPTH);

  logic [LANE_W-1:0] mem [DEPTH];
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic [AW:0]       count;
  logic              do_push;
  logic              do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == {(AW+1){1'b0}});
  assign occ     = count;
  assign head    = mem[rd_ptr];

  // Storage write; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and occupancy bookkeeping; clear empties the FIFO in one cycle.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rd_ptr <= {AW{1'b0}};
      wr_ptr <= {AW{1'b0}};
      count  <= {(AW+1){1'b0}};
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/mipi_pair_scheduler.sv
// Pairs lane A / lane B bytes into {B,A} words with enable/flush/drain
// sequencing and orphan-byte discard. Optional skew timeout is enabled by
// defining MIPI_PAIR_TIMEOUT_EN; without it skew_err is tied low.
module mipi_pair_scheduler
  import mipi_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              flush,
  input  logic [LANE_W-1:0] mipi_a,
  input  logic              mipi_a_valid,
  output logic              mipi_a_ready,
  input  logic [LANE_W-1:0] mipi_b,
  input  logic              mipi_b_valid,
  output logic              mipi_b_ready,
  output logic [PAIR_W-1:0] pair_out,
  output logic              pair_out_valid,
  input  logic              pair_out_ready,
  output logic [CNT_W-1:0]  pair_count,
  output logic [CNT_W-1:0]  drop_count,
  output logic              skew_err,
  output logic              busy
);

  localparam int OW = $clog2(FIFO_DEPTH) + 1;

  state_t            state;
  state_t            state_nxt;
  logic              a_push, b_push;
  logic              a_clear, b_clear;
  logic              a_full, b_full;
  logic              a_empty, b_empty;
  logic [OW-1:0]     a_occ, b_occ;
  logic [LANE_W-1:0] a_head, b_head;
  logic              pair_fire;
  logic              handshake;
  logic              to_fire;
  logic [CNT_W-1:0]  drop_add;

  // Saturating add through a one-bit-wider intermediate.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] base,
                                               input logic [CNT_W-1:0] inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, base} + {1'b0, inc};
    if (sum[CNT_W]) begin
      return {CNT_W{1'b1}};
    end else begin
      return sum[CNT_W-1:0];
    end
  endfunction

  assign mipi_a_ready = (state == RUN) & ~a_full & ~flush;
  assign mipi_b_ready = (state == RUN) & ~b_full & ~flush;
  assign a_push       = mipi_a_valid & mipi_a_ready;
  assign b_push       = mipi_b_valid & mipi_b_ready;
  assign handshake    = pair_out_valid & pair_out_ready;
  assign busy         = (state != IDLE);

  mipi_lane_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_a (
    .clk   (clk),
    .rst   (rst),
    .push  (a_push),
    .pop   (pair_fire),
    .clear (a_clear),
    .din   (mipi_a),
    .head  (a_head),
    .full  (a_full),
    .empty (a_empty),
    .occ   (a_occ)
  );

  mipi_lane_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_b (
    .clk   (clk),
    .rst   (rst),
    .push  (b_push),
    .pop   (pair_fire),
    .clear (b_clear),
    .din   (mipi_b),
    .head  (b_head),
    .full  (b_full),
    .empty (b_empty),
    .occ   (b_occ)
  );

`ifdef MIPI_PAIR_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] to_cnt;
  logic          lone;
  logic          skew_q;

  assign lone     = (state == RUN) & (a_empty ^ b_empty);
  assign to_fire  = lone & (to_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign skew_err = skew_q;

  // Skew timer: counts consecutive one-sided RUN cycles, pulses on expiry.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= {TW{1'b0}};
      skew_q <= 1'b0;
    end else if (to_fire) begin
      to_cnt <= {TW{1'b0}};
      skew_q <= 1'b1;
    end else if (lone) begin
      to_cnt <= to_cnt + 1'b1;
      skew_q <= 1'b0;
    end else begin
      to_cnt <= {TW{1'b0}};
      skew_q <= 1'b0;
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = (TIMEOUT_CYCLES > 0);
  assign to_fire        = 1'b0;
  assign skew_err       = 1'b0;
`endif

  // Pairing decision plus which lanes get discarded and how many bytes.
  always_comb begin
    pair_fire = 1'b0;
    a_clear   = 1'b0;
    b_clear   = 1'b0;
    drop_add  = {CNT_W{1'b0}};
    if (((state == RUN) || (state == DRAIN)) && !a_empty && !b_empty &&
        (!pair_out_valid || pair_out_ready)) begin
      pair_fire = 1'b1;
    end else begin
      pair_fire = 1'b0;
    end
    case (state)
      FLUSH: begin
        a_clear  = 1'b1;
        b_clear  = 1'b1;
        drop_add = CNT_W'(a_occ) + CNT_W'(b_occ);
      end
      DRAIN: begin
        if (!a_empty && b_empty) begin
          a_clear  = 1'b1;
          drop_add = CNT_W'(a_occ);
        end else if (a_empty && !b_empty) begin
          b_clear  = 1'b1;
          drop_add = CNT_W'(b_occ);
        end else begin
          drop_add = {CNT_W{1'b0}};
        end
      end
      default: begin
        drop_add = {CNT_W{1'b0}};
      end
    endcase
    // A byte pushed into the orphaned lane on the expiry edge is lost too.
    if (to_fire) begin
      if (!a_empty) begin
        a_clear  = 1'b1;
        drop_add = CNT_W'(a_occ) + CNT_W'(a_push);
      end else begin
        b_clear  = 1'b1;
        drop_add = CNT_W'(b_occ) + CNT_W'(b_push);
      end
    end else begin
      drop_add = drop_add;
    end
  end

  // Next-state logic; flush outranks enable.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (enable) state_nxt = RUN;
        else        state_nxt = IDLE;
      end
      RUN: begin
        if (flush)        state_nxt = FLUSH;
        else if (!enable) state_nxt = DRAIN;
        else              state_nxt = RUN;
      end
      DRAIN: begin
        if (flush)                                        state_nxt = FLUSH;
        else if (enable)                                  state_nxt = RUN;
        else if (a_empty && b_empty && !pair_out_valid)   state_nxt = IDLE;
        else                                              state_nxt = DRAIN;
      end
      FLUSH: begin
        if (enable) state_nxt = RUN;
        else        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Output word register: loads on a pair, holds until its handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      pair_out       <= {PAIR_W{1'b0}};
      pair_out_valid <= 1'b0;
    end else if (pair_fire) begin
      pair_out       <= pack_pair(b_head, a_head);
      pair_out_valid <= 1'b1;
    end else if (handshake) begin
      pair_out_valid <= 1'b0;
    end
  end

  // Saturating delivered-word and dropped-byte statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      pair_count <= {CNT_W{1'b0}};
      drop_count <= {CNT_W{1'b0}};
    end else begin
      if (handshake) begin
        pair_count <= sat_add(pair_count, CNT_W'(1'b1));
      end
      drop_count <= sat_add(drop_count, drop_add);
    end
  end

endmodule

// File: tb/tb_mipi_pair_scheduler.sv
// Testbench for mipi_pair_scheduler: a vector table for basic pairing,
// directed corner sequences and randomized traffic against a queue model.
module tb_mipi_pair_scheduler;

  localparam int DEPTH = 4;
  localparam int CW    = 16;
`ifdef MIPI_PAIR_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 64;
`endif

  logic        clk = 1'b0;
  logic        rst, enable, flush;
  logic [7:0]  mipi_a, mipi_b;
  logic        mipi_a_valid, mipi_b_valid, mipi_a_ready, mipi_b_ready;
  logic [15:0] pair_out;
  logic        pair_out_valid, pair_out_ready;
  logic [CW-1:0] pair_count, drop_count;
  logic        skew_err, busy;

  always #5 clk = ~clk;

  mipi_pair_scheduler #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .flush(flush),
    .mipi_a(mipi_a), .mipi_a_valid(mipi_a_valid), .mipi_a_ready(mipi_a_ready),
    .mipi_b(mipi_b), .mipi_b_valid(mipi_b_valid), .mipi_b_ready(mipi_b_ready),
    .pair_out(pair_out), .pair_out_valid(pair_out_valid), .pair_out_ready(pair_out_ready),
    .pair_count(pair_count), .drop_count(drop_count), .skew_err(skew_err), .busy(busy)
  );

  // ---------------- reference model (queues + counters) ----------------
  int          m_mode;   // 0 idle, 1 run, 2 drain, 3 flush
  logic [7:0]  qa[$];
  logic [7:0]  qb[$];
  logic        m_ov;
  logic [15:0] m_out;
  int          m_pc, m_dc, m_tc;
  logic        m_skew;

  int n_chk  = 0;
  int n_fail = 0;
  logic [15:0] got[$];

  function automatic int sat(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  function automatic bit m_ready_a();
    return (m_mode == 1) && (qa.size() < DEPTH) && !flush;
  endfunction

  function automatic bit m_ready_b();
    return (m_mode == 1) && (qb.size() < DEPTH) && !flush;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    bit ra, rb, acc_a, acc_b, hs, pr, lone, ov0;
    int na, nb;
    logic [7:0] ha, hb;
    if (rst) begin
      m_mode = 0; qa.delete(); qb.delete(); m_ov = 0; m_out = 16'h0000;
      m_pc = 0; m_dc = 0; m_tc = 0; m_skew = 0;
      return;
    end
    ra = m_ready_a(); rb = m_ready_b();
    acc_a = mipi_a_valid && ra;
    acc_b = mipi_b_valid && rb;
    na = qa.size(); nb = qb.size(); ov0 = m_ov;
    lone = (na > 0) != (nb > 0);
    hs = m_ov && pair_out_ready;
    pr = (m_mode == 1 || m_mode == 2) && na > 0 && nb > 0 && (!m_ov || pair_out_ready);
    if (hs) m_pc = sat(m_pc + 1);
    if (pr) begin
      ha = qa.pop_front(); hb = qb.pop_front();
      m_out = {hb, ha}; m_ov = 1;
    end else if (hs) begin
      m_ov = 0;
    end
    if (acc_a) qa.push_back(mipi_a);
    if (acc_b) qb.push_back(mipi_b);
    m_skew = 0;
    if (m_mode == 3 || (m_mode == 2 && lone)) begin
      m_dc = sat(m_dc + qa.size() + qb.size());
      qa.delete(); qb.delete();
    end
`ifdef MIPI_PAIR_TIMEOUT_EN
    if (m_mode == 1 && lone) begin
      m_tc++;
      if (m_tc == TO) begin
        m_skew = 1; m_tc = 0;
        if (na > 0) begin m_dc = sat(m_dc + qa.size()); qa.delete(); end
        else        begin m_dc = sat(m_dc + qb.size()); qb.delete(); end
      end
    end else begin
      m_tc = 0;
    end
`endif
    case (m_mode)
      0: m_mode = enable ? 1 : 0;
      1: m_mode = flush ? 3 : (!enable ? 2 : 1);
      2: m_mode = flush ? 3 : (enable ? 1 : ((na == 0 && nb == 0 && !ov0) ? 0 : 2));
      default: m_mode = enable ? 1 : 0;
    endcase
  endtask

  // One clock: check readies, capture handshakes, advance, compare outputs.
  task automatic step();
    #1;
    chk("ready_a", mipi_a_ready, m_ready_a());
    chk("ready_b", mipi_b_ready, m_ready_b());
    if (pair_out_valid && pair_out_ready && !rst) got.push_back(pair_out);
    @(posedge clk);
    model_update();
    @(negedge clk);
    chk("pair_valid", pair_out_valid, m_ov);
    if (m_ov) chk("pair_out", pair_out, m_out);
    chk("pair_count", pair_count, m_pc);
    chk("drop_count", drop_count, m_dc);
    chk("busy", busy, (m_mode != 0));
    chk("skew_err", skew_err, m_skew);
  endtask

  task automatic idle_inputs();
    flush = 0; mipi_a_valid = 0; mipi_b_valid = 0; mipi_a = 8'h00; mipi_b = 8'h00;
  endtask

  task automatic do_reset();
    rst = 1; enable = 0; pair_out_ready = 0; idle_inputs();
    step();
    rst = 0; got.delete();
  endtask

  typedef struct {
    logic en; logic va; logic [7:0] a; logic vb; logic [7:0] b; logic prdy;
    logic e_ov; logic [15:0] e_out; logic [15:0] e_pc; logic e_busy;
  } vec_t;

  vec_t vt[12];
  int   ka, kb, pulses, pulse_at;
  bit   acc_a, acc_b;

  initial begin
    vt[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 16'h0000, 16'd0, 1'b1};
    vt[1]  = '{1'b1, 1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b0, 16'h0000, 16'd0, 1'b1};
    vt[2]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 16'h2211, 16'd0, 1'b1};
    vt[3]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 16'h0000, 16'd1, 1'b1};
    vt[4]  = '{1'b1, 1'b1, 8'hA5, 1'b1, 8'h5A, 1'b0, 1'b0, 16'h0000, 16'd1, 1'b1};
    vt[5]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 16'h5AA5, 16'd1, 1'b1};
    vt[6]  = '{1'b1, 1'b1, 8'h01, 1'b1, 8'h02, 1'b0, 1'b1, 16'h5AA5, 16'd1, 1'b1};
    vt[7]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 16'h5AA5, 16'd1, 1'b1};
    vt[8]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 16'h0201, 16'd2, 1'b1};
    vt[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 16'h0000, 16'd3, 1'b1};
    vt[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 16'h0000, 16'd3, 1'b0};
    vt[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 16'h0000, 16'd3, 1'b0};

    rst = 1; enable = 0; pair_out_ready = 0; idle_inputs();
    @(negedge clk);
    do_reset();
    #1;
    chk("rst_pair_out", pair_out, 16'h0000);
    chk("rst_valid", pair_out_valid, 1'b0);
    chk("rst_ready_a", mipi_a_ready, 1'b0);
    chk("rst_ready_b", mipi_b_ready, 1'b0);
    chk("rst_counts", {pair_count, drop_count}, 32'h0);
    chk("rst_busy", busy, 1'b0);

    // Basic pairing / hold / drain-to-idle vector table
    for (int i = 0; i < 12; i++) begin
      enable = vt[i].en; mipi_a_valid = vt[i].va; mipi_a = vt[i].a;
      mipi_b_valid = vt[i].vb; mipi_b = vt[i].b; pair_out_ready = vt[i].prdy;
      step();
      chk($sformatf("vec%0d_valid", i), pair_out_valid, vt[i].e_ov);
      if (vt[i].e_ov) chk($sformatf("vec%0d_out", i), pair_out, vt[i].e_out);
      chk($sformatf("vec%0d_pcnt", i), pair_count, vt[i].e_pc);
      chk($sformatf("vec%0d_busy", i), busy, vt[i].e_busy);
    end

    // Skewed lanes: 4 A bytes, then 4 B bytes
    do_reset(); enable = 1; step();
    for (int i = 0; i < 4; i++) begin
      mipi_a_valid = 1; mipi_a = 8'hA0 + 8'(i); step();
    end
    mipi_a = 8'hAF; #1; chk("skew_a_ready_full", mipi_a_ready, 1'b0);
    step();
    mipi_a_valid = 0; pair_out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      mipi_b_valid = 1; mipi_b = 8'hB0 + 8'(i); step();
    end
    mipi_b_valid = 0;
    for (int i = 0; i < 4; i++) step();
    chk("skew_words", got.size(), 4);
    for (int i = 0; i < 4; i++) chk("skew_word", got[i], 16'hB0A0 + 16'h0101 * 16'(i));

    // Backpressure: 10 cycles unready with both lanes streaming
    do_reset(); enable = 1; step();
    ka = 0; kb = 0;
    for (int i = 0; i < 10; i++) begin
      mipi_a_valid = 1; mipi_b_valid = 1;
      mipi_a = 8'h30 + 8'(ka); mipi_b = 8'h60 + 8'(kb); pair_out_ready = 0;
      acc_a = m_ready_a(); acc_b = m_ready_b();
      step();
      if (acc_a) ka++;
      if (acc_b) kb++;
      if (i >= 1) chk("bp_hold", pair_out, 16'h6030);
    end
    #1;
    chk("bp_ready_a_full", mipi_a_ready, 1'b0);
    chk("bp_ready_b_full", mipi_b_ready, 1'b0);
    mipi_a_valid = 0; mipi_b_valid = 0; pair_out_ready = 1;
    for (int i = 0; i < 8; i++) step();
    chk("bp_words", got.size(), 5);
    for (int i = 0; i < 5; i++) chk("bp_word", got[i], 16'h6030 + 16'h0101 * 16'(i));

    // Flush with a held output word
    do_reset(); enable = 1; step();
    mipi_a_valid = 1; mipi_a = 8'hC1; mipi_b_valid = 1; mipi_b = 8'hD1; step();
    mipi_a = 8'hC2; mipi_b = 8'hD2; step();
    mipi_b_valid = 0; mipi_a = 8'hC3; step();
    mipi_a = 8'hC4; step();
    flush = 1; mipi_a = 8'hEE;
    #1; chk("flush_ready_a", mipi_a_ready, 1'b0);
    step();
    flush = 0; mipi_a_valid = 0; step();
    chk("flush_drop", drop_count, 16'd4);
    chk("flush_hold_valid", pair_out_valid, 1'b1);
    chk("flush_hold_word", pair_out, 16'hD1C1);
    pair_out_ready = 1; step();
    chk("flush_delivered", got.size(), 1);
    chk("flush_word", got[0], 16'hD1C1);
    pair_out_ready = 0; step();
    chk("flush_empty", pair_out_valid, 1'b0);

    // Lone lane: timeout pulse (or none without the option)
    do_reset(); enable = 1; step();
    pulses = 0; pulse_at = -1;
    for (int i = 1; i <= 100; i++) begin
      mipi_a_valid = (i <= 2); mipi_a = 8'hE0 + 8'(i);
      step();
      if (skew_err) begin pulses++; pulse_at = i; end
    end
    mipi_a_valid = 0;
`ifdef MIPI_PAIR_TIMEOUT_EN
    chk("to_pulses", pulses, 1);
    chk("to_pulse_cycle", pulse_at, 9);
    chk("to_drop", drop_count, 16'd2);
`else
    chk("to_pulses", pulses, 0);
    chk("to_drop", drop_count, 16'd0);
`endif

    // Disable drain: 2 pairs + 1 orphan A
    do_reset(); enable = 1; step();
    mipi_a_valid = 1; mipi_a = 8'h41; mipi_b_valid = 1; mipi_b = 8'h81; step();
    mipi_a = 8'h42; mipi_b = 8'h82; step();
    mipi_b_valid = 0; mipi_a = 8'h43; step();
    mipi_a_valid = 0; enable = 0; pair_out_ready = 1;
    for (int i = 0; i < 3; i++) step();
    chk("drain_words", got.size(), 2);
    chk("drain_word0", got[0], 16'h8141);
    chk("drain_word1", got[1], 16'h8242);
    chk("drain_drop", drop_count, 16'd1);
    chk("drain_busy", busy, 1'b0);

    // Randomized traffic including flushes, disables and resets
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst            = ($urandom_range(0, 499) == 0);
      enable         = ($urandom_range(0, 9) != 0);
      flush          = ($urandom_range(0, 39) == 0);
      mipi_a_valid   = ($urandom_range(0, 2) != 0);
      mipi_b_valid   = ($urandom_range(0, 3) != 0);
      mipi_a         = 8'($urandom);
      mipi_b         = 8'($urandom);
      pair_out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    rst = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
